prpg_seq_ctrl: RTL and testbench

- Instruction sequencer for the 8-bit PRPG LFSR datapath.
- Fetches 14-bit instructions from an asynchronous program ROM and decodes the 6-bit opcode plus 8-bit immediate.
- Issues one-hot control strobes to the LFSR and pattern-memory datapath.
- Owns the program counter, the memory address register and the multi-cycle run/batch step counter.

---
 rtl/prpg_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_prpg_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prpg_seq_ctrl.sv
// Instruction sequencer for the 8-bit PRPG LFSR datapath: fetch/decode of
// 14-bit ROM words, strobe generation, PC, address register and step counter.
module prpg_seq_ctrl #(
  parameter int PC_W   = 6,
  parameter int ADDR_W = 8,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [13:0]       instr,
  output logic [IMM_W-1:0]  imm,
  output logic              tap_we,
  output logic              seed_we,
  output logic              lfsr_step,
  output logic              mem_we,
  output logic [1:0]        mem_wsel,
  output logic              mem_re,
  output logic              ld_p,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | latch ROM word into ir
  // EXEC  | decode ir, single-cycle ops complete here
  // RUN   | multi-cycle LFSR stepping (plain or batch write)
  // LOAD  | second cycle of load, P takes memory read data
  // HALT  | stopped, outputs held until start
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RUN, LOAD, HALT} state_t;

  localparam logic [5:0] OP_HALT      = 6'd0;
  localparam logic [5:0] OP_CONFIG    = 6'd1;
  localparam logic [5:0] OP_SEED      = 6'd2;
  localparam logic [5:0] OP_RUN       = 6'd3;
  localparam logic [5:0] OP_INIT_ADDR = 6'd4;
  localparam logic [5:0] OP_STORE_P   = 6'd5;
  localparam logic [5:0] OP_ADD_ADDR  = 6'd6;
  localparam logic [5:0] OP_LOAD      = 6'd7;
  localparam logic [5:0] OP_STORE_HD  = 6'd8;
  localparam logic [5:0] OP_BATCH     = 6'd9;

  state_t           state;
  logic [13:0]      ir;
  logic [IMM_W-1:0] cnt;
  logic             batch;
  logic [5:0]       op;
  logic [IMM_W-1:0] ir_imm;

  assign op     = ir[13:8];
  assign ir_imm = ir[IMM_W-1:0];
  assign imm    = ir_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      addr        <= '0;
      ir          <= '0;
      cnt         <= '0;
      batch       <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir    <= instr;
          state <= EXEC;
        end
        EXEC: begin
          // default path: single-cycle op, advance to the next word
          state <= FETCH;
          pc    <= pc + PC_W'(1);
          case (op)
            OP_HALT: begin
              state <= HALT;
              pc    <= pc;
            end
            OP_RUN, OP_BATCH: begin
              cnt   <= ir_imm;
              batch <= (op == OP_BATCH);
              if (ir_imm != '0) begin
                state <= RUN;
                pc    <= pc;
              end
            end
            OP_INIT_ADDR: addr <= ADDR_W'(ir_imm);
            OP_ADD_ADDR:  addr <= addr + ADDR_W'(ir_imm);
            OP_LOAD: begin
              state <= LOAD;
              pc    <= pc;
            end
            OP_CONFIG, OP_SEED, OP_STORE_P, OP_STORE_HD: ;
            default: begin
              err_illegal <= 1'b1;
              state       <= HALT;
              pc          <= pc;
            end
          endcase
        end
        RUN: begin
          cnt <= cnt - IMM_W'(1);
          if (batch) addr <= addr + ADDR_W'(1);
          if (cnt == IMM_W'(1)) begin
            state <= FETCH;
            pc    <= pc + PC_W'(1);
          end
        end
        LOAD: begin
          state <= FETCH;
          pc    <= pc + PC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // strobes depend only on registered state, so reset clears them at once
  always_comb begin
    tap_we    = 1'b0;
    seed_we   = 1'b0;
    lfsr_step = 1'b0;
    mem_we    = 1'b0;
    mem_wsel  = 2'd0;
    mem_re    = 1'b0;
    ld_p      = 1'b0;
    case (state)
      EXEC: begin
        case (op)
          OP_CONFIG:   tap_we  = 1'b1;
          OP_SEED:     seed_we = 1'b1;
          OP_STORE_P:  mem_we  = 1'b1;
          OP_LOAD:     mem_re  = 1'b1;
          OP_STORE_HD: begin
            mem_we   = 1'b1;
            mem_wsel = 2'd2;
          end
          default: ;
        endcase
      end
      RUN: begin
        lfsr_step = 1'b1;
        if (batch) begin
          mem_we   = 1'b1;
          mem_wsel = 2'd1;
        end
      end
      LOAD:    ld_p = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_prpg_seq_ctrl.sv
// Scoreboard bench for prpg_seq_ctrl: expected strobe events are queued per
// program and matched against strobes observed each cycle.
module tb_prpg_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  pc;
  logic [13:0] instr;
  logic [7:0]  imm;
  logic        tap_we, seed_we, lfsr_step, mem_we, mem_re, ld_p;
  logic [1:0]  mem_wsel;
  logic [7:0]  addr;
  logic        busy, halted, err_illegal;

  logic [13:0] rom [64];
  logic [31:0] exp_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  assign instr = rom[pc];

  always #5 clk = ~clk;

  prpg_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr), .imm(imm),
    .tap_we(tap_we), .seed_we(seed_we), .lfsr_step(lfsr_step), .mem_we(mem_we),
    .mem_wsel(mem_wsel), .mem_re(mem_re), .ld_p(ld_p), .addr(addr),
    .busy(busy), .halted(halted), .err_illegal(err_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // event word: kind | wsel | addr | imm
  function automatic logic [31:0] ev(input logic [3:0] k, input logic [1:0] ws,
                                     input logic [7:0] a, input logic [7:0] im);
    return {10'd0, k, ws, a, im};
  endfunction

  function automatic logic [13:0] ins(input logic [5:0] op, input logic [7:0] im);
    return {op, im};
  endfunction

  task automatic push_batch(input logic [7:0] a);
    exp_q.push_back(ev(4'd3, 2'd0, 8'd0, 8'd0));
    exp_q.push_back(ev(4'd4, 2'd1, a, 8'd0));
  endtask

  task automatic obs_evt(input logic [31:0] e);
    if (exp_q.size() == 0) chk("extra_strobe", e, 32'd0);
    else chk("strobe", e, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tap_we)    obs_evt(ev(4'd1, 2'd0, 8'd0, imm));
      if (seed_we)   obs_evt(ev(4'd2, 2'd0, 8'd0, imm));
      if (lfsr_step) obs_evt(ev(4'd3, 2'd0, 8'd0, 8'd0));
      if (mem_we)    obs_evt(ev(4'd4, mem_wsel, addr, 8'd0));
      if (mem_re)    obs_evt(ev(4'd5, 2'd0, addr, 8'd0));
      if (ld_p)      obs_evt(ev(4'd6, 2'd0, 8'd0, 8'd0));
    end
  end

  // pulse start, count edges until halted, bounded
  task automatic run_prog(input string tag, input int exp_cyc);
    int cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    while (!halted && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] strobes();
    return 32'({tap_we, seed_we, lfsr_step, mem_we, mem_re, ld_p, mem_wsel});
  endfunction

  initial begin
    rom = '{default: 14'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_flags", 32'({busy, halted, err_illegal}), 32'd0);
    chk("rst_strobes", strobes(), 32'd0);
    rst_n = 1'b1;

    // config / seed / halt
    rom[0] = ins(6'd1, 8'h25);
    rom[1] = ins(6'd2, 8'hFF);
    exp_q.push_back(ev(4'd1, 2'd0, 8'd0, 8'h25));
    exp_q.push_back(ev(4'd2, 2'd0, 8'd0, 8'hFF));
    run_prog("cfg", 6);
    chk("cfg_pc", 32'(pc), 32'd2);
    chk("cfg_halt", 32'({busy, halted}), 32'b01);

    // batch 3 from 0x01
    rom = '{default: 14'd0};
    rom[0] = ins(6'd4, 8'h01);
    rom[1] = ins(6'd9, 8'd3);
    push_batch(8'h01); push_batch(8'h02); push_batch(8'h03);
    run_prog("batch3", 9);
    chk("batch3_addr", 32'(addr), 32'h04);
    chk("batch3_pc", 32'(pc), 32'd2);

    // batch wrap, run 0, batch 0
    rom = '{default: 14'd0};
    rom[0] = ins(6'd4, 8'hFE);
    rom[1] = ins(6'd9, 8'd4);
    rom[2] = ins(6'd3, 8'd0);
    rom[3] = ins(6'd9, 8'd0);
    push_batch(8'hFE); push_batch(8'hFF); push_batch(8'h00); push_batch(8'h01);
    run_prog("wrap", 14);
    chk("wrap_addr", 32'(addr), 32'h02);
    chk("wrap_pc", 32'(pc), 32'd4);

    // load, add_addr, stores, plain run
    rom = '{default: 14'd0};
    rom[0] = ins(6'd4, 8'h03);
    rom[1] = ins(6'd7, 8'h00);
    rom[2] = ins(6'd4, 8'h20);
    rom[3] = ins(6'd6, 8'hF0);
    rom[4] = ins(6'd5, 8'h00);
    rom[5] = ins(6'd8, 8'h00);
    rom[6] = ins(6'd3, 8'd2);
    exp_q.push_back(ev(4'd5, 2'd0, 8'h03, 8'd0));
    exp_q.push_back(ev(4'd6, 2'd0, 8'd0, 8'd0));
    exp_q.push_back(ev(4'd4, 2'd0, 8'h10, 8'd0));
    exp_q.push_back(ev(4'd4, 2'd2, 8'h10, 8'd0));
    exp_q.push_back(ev(4'd3, 2'd0, 8'd0, 8'd0));
    exp_q.push_back(ev(4'd3, 2'd0, 8'd0, 8'd0));
    run_prog("load", 19);
    chk("load_addr", 32'(addr), 32'h10);
    chk("load_pc", 32'(pc), 32'd7);

    // illegal opcode at pc 5, then restart
    rom = '{default: 14'd0};
    rom[0] = ins(6'd1, 8'h01);
    rom[1] = ins(6'd2, 8'h02);
    rom[2] = ins(6'd4, 8'h40);
    rom[3] = ins(6'd3, 8'd0);
    rom[4] = ins(6'd9, 8'd0);
    rom[5] = ins(6'h0C, 8'h00);
    exp_q.push_back(ev(4'd1, 2'd0, 8'd0, 8'h01));
    exp_q.push_back(ev(4'd2, 2'd0, 8'd0, 8'h02));
    run_prog("illegal", 12);
    chk("illegal_flags", 32'({halted, err_illegal}), 32'b11);
    chk("illegal_pc", 32'(pc), 32'd5);
    rom = '{default: 14'd0};
    run_prog("restart", 2);
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_err", 32'(err_illegal), 32'd1);
    chk("restart_addr", 32'(addr), 32'h40);

    // reset in the 2nd cycle of batch 10
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst2_err", 32'(err_illegal), 32'd0);
    rom = '{default: 14'd0};
    rom[0] = ins(6'd9, 8'd10);
    push_batch(8'h00); push_batch(8'h01);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #7 rst_n = 1'b0;
    #1;
    chk("midrst_strobes", strobes(), 32'd0);
    chk("midrst_state", 32'({busy, halted}), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'({busy, halted}), 32'd0);
    chk("post_rst_pc", 32'(pc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
